cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pipe_adder.sv | 158 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder, WIDTH/(4*GPS) stages with valid/ready flow control.
// Define CLA_PIPE_OVF_EN to add the signed-overflow output ovf (carried down the pipe, aligned with sum).
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW   = 4 * GPS;
  localparam int NSTG = WIDTH / SW;

  if ((WIDTH % 4 != 0) || (WIDTH < 4) || (WIDTH > 64) || (GPS < 1) || ((WIDTH / 4) % GPS != 0)) begin : g_bad_param
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64 and WIDTH/4 divisible by GPS");
  end

  // Low bits of s are finished as the operand moves up; high bits of op_a/op_b are still to be added.
  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
  } stage_t;

  // One 4-bit lookahead group: every carry is a flat sum of products of p/g and the group carry-in.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] p, g, t, c;
    logic       co;
    p    = x | y;
    g    = x & y;
    t    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {co, t ^ c};
  endfunction

  // GPS groups per stage; the group-to-group carry ripples inside the stage.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic c0);
    logic [SW-1:0] s;
    logic [4:0]    r;
    logic          c;
    s = '0;
    c = c0;
    for (int gi = 0; gi < GPS; gi++) begin
      r            = cla4(x[4*gi +: 4], y[4*gi +: 4], c);
      s[4*gi +: 4] = r[3:0];
      c            = r[4];
    end
    return {c, s};
  endfunction

  logic            run_q;
  logic [NSTG-1:0] vld_q, vld_d;
  stage_t          stg_q [NSTG];
  stage_t          stg_d [NSTG];
  stage_t          src   [NSTG];
  logic [NSTG-1:0] src_v;
  logic [NSTG-1:0] ready;
`ifdef CLA_PIPE_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  // A stage register may load when it is empty or its content moves on this cycle.
  always_comb begin
    ready           = '0;
    ready[NSTG-1]   = !vld_q[NSTG-1] || out_ready;
    for (int k = NSTG - 2; k >= 0; k--) begin
      ready[k] = !vld_q[k] || ready[k+1];
    end
  end

  always_comb begin
    src[0]   = '{carry: cin, s: '0, op_a: a, op_b: b};
    src_v[0] = in_valid && run_q;
    for (int k = 1; k < NSTG; k++) begin
      src[k]   = stg_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  // NOTE: every signal gets its default before any condition, so no path leaves it unassigned (no latch).
  always_comb begin
    logic [SW:0] r;
    r     = '0;
    vld_d = vld_q;
    stg_d = stg_q;
`ifdef CLA_PIPE_OVF_EN
    ovf_d = ovf_q;
`endif
    for (int k = 0; k < NSTG; k++) begin
      if (ready[k]) begin
        vld_d[k] = src_v[k];
      end
      if (ready[k] && src_v[k]) begin
        r                      = cla_slice(src[k].op_a[SW*k +: SW], src[k].op_b[SW*k +: SW],
                                           src[k].carry);
        stg_d[k]               = src[k];
        stg_d[k].s[SW*k +: SW] = r[SW-1:0];
        stg_d[k].carry         = r[SW];
`ifdef CLA_PIPE_OVF_EN
        if (k == NSTG - 1) begin
          ovf_d = (src[k].op_a[WIDTH-1] == src[k].op_b[WIDTH-1]) &&
                  (r[SW-1] != src[k].op_a[WIDTH-1]);
        end
`endif
      end
    end
  end

  // NOTE: the data registers are cleared on reset as well, so nothing stale can resurface after release.
  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      vld_q <= '0;
      for (int k = 0; k < NSTG; k++) begin
        stg_q[k] <= '0;
      end
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      vld_q <= vld_d;
      stg_q <= stg_d;
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  // run_q keeps in_ready low through reset and rises on the first clock after release.
  assign in_ready  = run_q && ready[0];
  assign out_valid = vld_q[NSTG-1];
  assign sum       = out_valid ? {stg_q[NSTG-1].carry, stg_q[NSTG-1].s} : '0;
`ifdef CLA_PIPE_OVF_EN
  assign ovf       = out_valid && ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (16-bit, GPS=1) plus a 32-bit GPS=2 instance under random traffic.
// Define CLA_PIPE_OVF_EN to also check the ovf output.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready;
  logic [15:0] a, b;
  logic [16:0] sum;
  logic        ovf;

  logic        in_valid2, in_ready2, cin2, out_valid2, out_ready2;
  logic [31:0] a2, b2;
  logic [32:0] sum2;
  logic        ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .GPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  cla_pipe_adder #(.WIDTH(32), .GPS(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(ovf2)
`endif
  );

`ifndef CLA_PIPE_OVF_EN
  assign ovf  = 1'b0;
  assign ovf2 = 1'b0;
`endif

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || sum !== 17'h0 || in_ready !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got out_valid=%b sum=%h in_ready=%b ovf=%b expected 0 0 0 0",
               out_valid, sum, in_ready, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL release_before_clk in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL first_clk_in_ready: got %b/%b expected 1/1", in_ready, in_ready2);
    end
  endtask

  // One operand through an otherwise empty pipe; checks latency, sum and (with the macro) ovf.
  task automatic run_single(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                            input logic [16:0] exp_sum, input logic exp_ovf, input string name);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk);
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++; $display("FAIL %s latency: got %0d expected 4 (0 = timeout)", name, lat);
    end
    n_checks++;
    if (sum !== exp_sum) begin
      n_fail++; $display("FAIL %s sum: got %h expected %h", name, sum, exp_sum);
    end
`ifdef CLA_PIPE_OVF_EN
    n_checks++;
    if (ovf !== exp_ovf) begin
      n_fail++; $display("FAIL %s ovf: got %b expected %b", name, ovf, exp_ovf);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_carry();
    run_single(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0, "basic");
    run_single(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b0, "ripple_all");
    run_single(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0, "wrap_max");
    run_single(16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0, "zero");
    run_single(16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 1'b0, "group_carry");
  endtask

  task automatic test_ovf();
    run_single(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, "ovf_pos");
    run_single(16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1, "ovf_neg");
    run_single(16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0, "ovf_none");
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic [16:0] ve [8];
    logic [16:0] prev_sum;
    logic        prev_stall;
    int          in_idx, out_idx;
    va = '{16'h0001, 16'h00FF, 16'h1234, 16'hFFFF, 16'h8000, 16'hABCD, 16'hF0F0, 16'hC000};
    vb = '{16'h0001, 16'h0001, 16'h1111, 16'h0001, 16'h7FFF, 16'h1111, 16'h0F0F, 16'hC000};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ve = '{17'h00002, 17'h00100, 17'h02346, 17'h10000, 17'h10000, 17'h0BCDE, 17'h0FFFF, 17'h18001};
    in_idx = 0; out_idx = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 6 && cyc <= 9);
      in_valid  = (in_idx < 8);
      a   = (in_idx < 8) ? va[in_idx] : 16'h0;
      b   = (in_idx < 8) ? vb[in_idx] : 16'h0;
      cin = (in_idx < 8) ? vc[in_idx] : 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== prev_sum) begin
          n_fail++;
          $display("FAIL b2b_stall_hold cyc %0d: got valid=%b sum=%h expected 1 %h",
                   cyc, out_valid, sum, prev_sum);
        end
      end
      if (cyc < 10) begin
        n_checks++;
        if (in_ready !== (cyc < 6)) begin
          n_fail++;
          $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, (cyc < 6));
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (out_idx >= 8) begin
          n_fail++; $display("FAIL b2b_extra_result: got sum=%h expected no result", sum);
        end else if (sum !== ve[out_idx]) begin
          n_fail++; $display("FAIL b2b_result %0d: got %h expected %h", out_idx, sum, ve[out_idx]);
        end
        out_idx++;
      end
      if (in_valid && in_ready === 1'b1) in_idx++;
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_sum   = sum;
    end
    in_valid = 1'b0;
    n_checks++;
    if (in_idx != 8 || out_idx != 8) begin
      n_fail++; $display("FAIL b2b_counts: got in=%0d out=%0d expected 8 8", in_idx, out_idx);
    end
  endtask

  // Sparse operands under a stalled output collapse together, then a reset discards them.
  task automatic test_bubble_reset();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    va = '{16'h1234, 16'h0F0F, 16'h0002};
    vb = '{16'h4321, 16'h00F1, 16'h0003};
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL bubble_accept %0d: got in_ready=%b expected 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || sum !== 17'h05555 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_packed: got valid=%b sum=%h in_ready=%b expected 1 05555 1",
               out_valid, sum, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== 17'h0 || in_ready !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b sum=%h in_ready=%b ovf=%b expected 0 0 0 0",
               out_valid, sum, in_ready, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || sum !== 17'h0) begin
        n_fail++; $display("FAIL stale_after_reset %0d: got valid=%b sum=%h expected 0 0", n, out_valid, sum);
      end
    end
  endtask

  // 32-bit, two groups per stage: results compared against plain addition, in order.
  task automatic test_random32();
    logic [32:0] exp_q [$];
    logic [32:0] exp;
    int          sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid2  = (sent < 1000) && ($urandom_range(3) != 0);
      a2         = $urandom;
      b2         = $urandom;
      cin2       = 1'($urandom_range(1));
      out_ready2 = ($urandom_range(3) != 0);
      @(negedge clk);
      if (out_valid2 === 1'b1 && out_ready2) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand32_unexpected: got %h expected no result", sum2);
        end else begin
          exp = exp_q.pop_front();
          if (sum2 !== exp) begin
            n_fail++; $display("FAIL rand32_sum %0d: got %h expected %h", rcvd, sum2, exp);
          end
        end
        rcvd++;
      end
      if (in_valid2 && in_ready2 === 1'b1) begin
        exp_q.push_back({1'b0, a2} + {1'b0, b2} + {32'h0, cin2});
        sent++;
      end
      cyc++;
    end
    in_valid2 = 1'b0;
    n_checks++;
    if (rcvd != 1000) begin
      n_fail++; $display("FAIL rand32_count: got %0d expected 1000 (cycle budget)", rcvd);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_ovf();
    test_back_to_back();
    test_bubble_reset();
    test_random32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
